// File: rtl/fifo_word_packer.sv
// Packs successive FIFO entries into wide words with a per-lane keep mask.
// A flush request emits a partially filled word; the output register obeys valid/ready.
module fifo_word_packer #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned BYTES_PER_WORD = 4
) (
    input  logic                                 rclk,
    input  logic                                 rrst_n,
    input  logic                                 empty,
    input  logic [DATA_WIDTH-1:0]                data_out,
    output logic                                 r_en,
    input  logic                                 flush,
    output logic [DATA_WIDTH*BYTES_PER_WORD-1:0] m_data,
    output logic [BYTES_PER_WORD-1:0]            m_keep,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [15:0]                          word_cnt
);

    localparam int unsigned CW = $clog2(BYTES_PER_WORD + 1);
    localparam int unsigned WW = DATA_WIDTH * BYTES_PER_WORD;
    localparam logic [CW-1:0] Full = CW'(BYTES_PER_WORD);

    logic [CW-1:0]             cnt_q;
    logic                      inf_q;
    logic                      run_q;
    logic                      flush_pend_q;
    logic [WW-1:0]             asm_q;
    logic [WW-1:0]             m_data_q;
    logic [BYTES_PER_WORD-1:0] m_keep_q;
    logic                      m_valid_q;
    logic [15:0]               word_cnt_q;

    logic [CW-1:0]             fill;
    logic [CW-1:0]             post_cnt;
    logic                      out_free;
    logic                      word_done;
    logic                      xfer;
    logic [WW-1:0]             asm_cap;
    logic [WW-1:0]             word_new;
    logic [BYTES_PER_WORD-1:0] keep_new;

    always_comb begin
        // fill counts the lanes occupied once this edge's in-flight entry lands
        fill      = cnt_q + CW'(inf_q);
        out_free  = !m_valid_q || m_ready;
        word_done = (fill == Full) || (flush_pend_q && (cnt_q != '0) && !inf_q);
        xfer      = word_done && out_free;
        post_cnt  = xfer ? '0 : fill;
        r_en      = !empty && rrst_n && run_q && (post_cnt < Full);

        asm_cap  = asm_q;
        word_new = '0;
        keep_new = '0;
        for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
            if (inf_q && (cnt_q == CW'(i))) begin
                asm_cap[i*DATA_WIDTH +: DATA_WIDTH] = data_out;
            end
            if (CW'(i) < fill) begin
                keep_new[i]                          = 1'b1;
                word_new[i*DATA_WIDTH +: DATA_WIDTH] = asm_cap[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            cnt_q        <= '0;
            inf_q        <= 1'b0;
            run_q        <= 1'b0;
            flush_pend_q <= 1'b0;
            asm_q        <= '0;
            m_data_q     <= '0;
            m_keep_q     <= '0;
            m_valid_q    <= 1'b0;
            word_cnt_q   <= '0;
        end else begin
            // Holds r_en off until the first edge after reset release
            run_q <= 1'b1;
            inf_q <= r_en;
            cnt_q <= post_cnt;
            asm_q <= xfer ? '0 : asm_cap;

            if (xfer) begin
                flush_pend_q <= 1'b0;
            end else if (flush && ((cnt_q != '0) || inf_q)) begin
                flush_pend_q <= 1'b1;
            end

            if (xfer) begin
                m_data_q  <= word_new;
                m_keep_q  <= keep_new;
                m_valid_q <= 1'b1;
            end else if (m_ready) begin
                m_valid_q <= 1'b0;
            end

            if (m_valid_q && m_ready) begin
                word_cnt_q <= word_cnt_q + 16'd1;
            end
        end
    end

    assign m_data   = m_data_q;
    assign m_keep   = m_keep_q;
    assign m_valid  = m_valid_q;
    assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Scoreboard bench for fifo_word_packer: directed FIFO streams, a forked monitor
// compares each accepted output word against the queue of hand-computed words.
module tb_fifo_word_packer;

    localparam int unsigned DW  = 8;
    localparam int unsigned BPW = 4;

    logic           rclk = 1'b0;
    logic           rrst_n;
    logic           empty;
    logic [DW-1:0]  data_out;
    logic           r_en;
    logic           flush;
    logic [31:0]    m_data;
    logic [BPW-1:0] m_keep;
    logic           m_valid;
    logic           m_ready;
    logic [15:0]    word_cnt;

    fifo_word_packer #(
        .DATA_WIDTH    (DW),
        .BYTES_PER_WORD(BPW)
    ) dut (
        .rclk    (rclk),
        .rrst_n  (rrst_n),
        .empty   (empty),
        .data_out(data_out),
        .r_en    (r_en),
        .flush   (flush),
        .m_data  (m_data),
        .m_keep  (m_keep),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .word_cnt(word_cnt)
    );

    always #5 rclk = ~rclk;

    logic [7:0]  fifo_q[$];
    logic [35:0] exp_q[$];   // {keep, data}
    int total = 0;
    int bad = 0;
    int acc = 0;
    int vcyc = 0;
    int cyc = 0;
    int first_acc = -1;
    int last_acc = -1;
    logic rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic monitor();
        logic [35:0] e;
        forever begin
            @(negedge rclk);
            cyc++;
            if (rrst_n && m_valid) vcyc++;
            if (rrst_n && m_valid && m_ready) begin
                acc++;
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected_word: got data 0x%0h keep 0x%0h, none expected",
                             m_data, m_keep);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_word_data", m_data, e[31:0]);
                    check("sb_word_keep", 32'(m_keep), 32'(e[35:32]));
                end
            end
        end
    endtask

    // One cycle of the FIFO model: a read requested in this cycle yields data the next cycle
    task automatic tick();
        @(negedge rclk);
        rd = r_en;
        @(posedge rclk);
        #1;
        if (rd && fifo_q.size() > 0) data_out = fifo_q.pop_front();
        empty = (fifo_q.size() == 0);
    endtask

    task automatic push(input logic [7:0] v);
        fifo_q.push_back(v);
        empty = 1'b0;
    endtask

    task automatic wait_acc(input int target, input int budget, input string name);
        int n = 0;
        while (acc < target && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(acc), 32'(target));
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic do_reset();
        rrst_n  = 1'b0;
        m_ready = 1'b0;
        flush   = 1'b0;
        fifo_q.delete();
        empty   = 1'b1;
        repeat (2) tick();
        rrst_n = 1'b1;
        tick();
    endtask

    initial begin
        int b;
        int v0;
        logic [31:0] w;

        fork
            monitor();
        join_none

        rrst_n   = 1'b0;
        empty    = 1'b1;
        data_out = '0;
        flush    = 1'b0;
        m_ready  = 1'b0;
        repeat (2) tick();
        check("rst_r_en", 32'(r_en), 0);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_keep", 32'(m_keep), 0);
        check("rst_word_cnt", 32'(word_cnt), 0);
        rrst_n = 1'b1;
        tick();

        // Single full word, ready held high
        m_ready = 1'b1;
        b  = acc;
        v0 = vcyc;
        exp_q.push_back({4'hF, 32'h44332211});
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        wait_acc(b + 1, 20, "t1_word_seen");
        repeat (2) tick();
        check("t1_valid_cycles", 32'(vcyc - v0), 1);
        check("t1_word_cnt", 32'(word_cnt), 1);

        // Backpressure: two words assembled, ninth entry must stay in the FIFO
        m_ready = 1'b0;
        b = acc;
        exp_q.push_back({4'hF, 32'h04030201});
        exp_q.push_back({4'hF, 32'h08070605});
        for (int i = 1; i <= 9; i++) push(8'(i));
        repeat (14) tick();
        check("t2_r_en_held", 32'(r_en), 0);
        check("t2_fifo_left", 32'(fifo_q.size()), 1);
        check("t2_m_valid", 32'(m_valid), 1);
        check("t2_m_data", m_data, 32'h04030201);
        repeat (3) tick();
        check("t2_m_data_stable", m_data, 32'h04030201);
        m_ready = 1'b1;
        wait_acc(b + 2, 20, "t2_words_seen");
        exp_q.push_back({4'h1, 32'h00000009});
        repeat (3) tick();
        pulse_flush();
        wait_acc(b + 3, 20, "t2_tail_flushed");
        check("t2_word_cnt", 32'(word_cnt), 4);

        // Partial word by flush, then flush with nothing buffered
        b = acc;
        exp_q.push_back({4'h3, 32'h0000BBAA});
        push(8'hAA); push(8'hBB);
        repeat (5) tick();
        pulse_flush();
        wait_acc(b + 1, 20, "t3_partial_seen");
        pulse_flush();
        repeat (8) tick();
        check("t3_idle_flush_no_word", 32'(acc), 32'(b + 1));
        check("t3_idle_m_valid", 32'(m_valid), 0);
        check("t3_word_cnt", 32'(word_cnt), 5);

        // 64-entry stream: one word every four cycles, no bubbles
        do_reset();
        check("t4_word_cnt_reset", 32'(word_cnt), 0);
        m_ready   = 1'b1;
        b         = acc;
        first_acc = -1;
        for (int k = 0; k < 16; k++) begin
            w = {8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1), 8'(4 * k)};
            exp_q.push_back({4'hF, w});
        end
        for (int i = 0; i < 64; i++) push(8'(i));
        wait_acc(b + 16, 200, "t4_words_seen");
        repeat (2) tick();
        check("t4_word_cnt", 32'(word_cnt), 16);
        check("t4_span_cycles", 32'(last_acc - first_acc), 60);

        // Asynchronous reset with a held word and three lanes filled
        do_reset();
        for (int i = 0; i < 7; i++) push(8'(8'h10 + i));
        repeat (14) tick();
        check("t5_pre_valid", 32'(m_valid), 1);
        rrst_n = 1'b0;
        #1;
        check("t5_async_m_valid", 32'(m_valid), 0);
        check("t5_async_m_data", m_data, 0);
        check("t5_async_m_keep", 32'(m_keep), 0);
        check("t5_async_r_en", 32'(r_en), 0);
        repeat (2) tick();
        fifo_q.delete();
        empty = 1'b1;
        push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
        rrst_n = 1'b1;
        #1;
        check("t5_no_early_r_en", 32'(r_en), 0);
        b = acc;
        exp_q.push_back({4'hF, 32'hD4C3B2A1});
        m_ready = 1'b1;
        wait_acc(b + 1, 20, "t5_word_seen");
        repeat (2) tick();
        check("t5_word_cnt", 32'(word_cnt), 1);

        // word_cnt wrap
        force dut.word_cnt_q = 16'hFFFF;
        tick();
        release dut.word_cnt_q;
        tick();
        check("t6_preset", 32'(word_cnt), 32'h0000FFFF);
        b = acc;
        exp_q.push_back({4'hF, 32'h78563412});
        push(8'h12); push(8'h34); push(8'h56); push(8'h78);
        wait_acc(b + 1, 20, "t6_word_seen");
        repeat (2) tick();
        check("t6_word_cnt_wrap", 32'(word_cnt), 0);

        check("sb_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
